// File: rtl/dmem_master.sv
// Sequences a 64-bit load/store from the memory stage into eight byte-wide
// accesses on a synchronous single-port RAM, returning one response per request.
module dmem_master #(
  parameter int MEM_BYTES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [63:0]                  req_addr_i,
  input  logic [63:0]                  req_wdata_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [63:0]                  rsp_rdata_o,
  output logic                         rsp_error_o,
  output logic                         mem_en_o,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr_o,
  output logic [7:0]                   mem_wdata_o,
  input  logic [7:0]                   mem_rdata_i
);
  localparam int          AW      = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_RESP} state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [2:0]    cnt_d;
  logic [2:0]    cnt_prev;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_error_q;
  logic [63:0]   rsp_rdata_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    mem_wdata_q;
  logic          we_q;
  logic [AW-1:0] base_q;
  logic [63:0]   wdata_q;
  logic          accept;
  logic          addr_err;

  assign accept   = (state_q == S_IDLE) && req_valid_i && req_ready_q;
  // Full-width unsigned compare so huge addresses can never alias into the RAM.
  assign addr_err = (req_addr_i > LAST_OK);
  assign cnt_d    = cnt_q + 3'd1;
  assign cnt_prev = cnt_q - 3'd1;

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= req_we_i;
      base_q  <= req_addr_i[AW-1:0];
      wdata_q <= req_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            cnt_q       <= 3'd0;
            if (addr_err) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
            end else begin
              state_q     <= S_XFER;
              mem_en_q    <= 1'b1;
              mem_we_q    <= req_we_i;
              mem_addr_q  <= req_addr_i[AW-1:0];
              mem_wdata_q <= req_wdata_i[7:0];
            end
          end
        end
        S_XFER: begin
          // RAM read data lags its strobe by one cycle, so capture the previous byte.
          if (!we_q && cnt_q != 3'd0)
            rsp_rdata_q[{cnt_prev, 3'b000} +: 8] <= mem_rdata_i;
          cnt_q <= cnt_d;
          if (cnt_q == 3'd7) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            if (we_q) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            mem_addr_q  <= base_q + AW'(cnt_d);
            mem_wdata_q <= wdata_q[{cnt_d, 3'b000} +: 8];
          end
        end
        S_DRAIN: begin
          rsp_rdata_q[63:56] <= mem_rdata_i;
          state_q            <= S_RESP;
          rsp_valid_q        <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_error_o = rsp_error_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
